// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_ILLEGAL  = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } fault_code_t;

  // Loads accept B/H/W/BU/HU; stores only have signless B/H/W.
  function automatic logic is_illegal(logic rd, logic wr, logic [2:0] f3);
    logic ill;
    ill = 1'b0;
    if (rd && wr) begin
      ill = 1'b1;
    end else if (rd) begin
      ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end else if (wr) begin
      ill = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    end
    return ill;
  endfunction

  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU)) begin
      mis = lo[0];
    end else if (f3 == F3_W) begin
      mis = (lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [DATA_W-1:0]   store_data_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   load_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_o    = '1;
    wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = (DATA_W/8)'(4'b0001) << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = (DATA_W/8)'(4'b0011) << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o    = '1;
        wdata_o = store_data_i;
      end
    endcase
  end

  always_comb begin
    byte_v      = 8'(rdata_i >> {addr_lo_i, 3'b000});
    half_v      = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});
    load_data_o = rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      F3_BU:   load_data_o = {{(DATA_W-8){1'b0}}, byte_v};
      F3_H:    load_data_o = {{(DATA_W-16){half_v[15]}}, half_v};
      F3_HU:   load_data_o = {{(DATA_W-16){1'b0}}, half_v};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one req/ready data-memory access per
// EX/MEM instruction, stalls the pipe while it is outstanding, reports faults.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [2:0]          funct3_i,
  input  logic [DATA_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   store_data_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [DATA_W-1:0]   dmem_addr_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  output logic [DATA_W/8-1:0] dmem_be_o,
  input  logic                dmem_ready_i,
  input  logic [DATA_W-1:0]   dmem_rdata_i,
  output logic [DATA_W-1:0]   load_data_o,
  output logic                done_o,
  output logic                stall_o,
  output logic                fault_o,
  output logic [1:0]          fault_code_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                we_q, we_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  fault_code_t         fault_q, fault_d;

  logic                access;
  logic                illegal;
  logic                misalign;
  logic                busy;
  logic [2:0]          al_funct3;
  logic [1:0]          al_addr_lo;
  logic [DATA_W/8-1:0] al_be;
  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W-1:0]   al_load;

  assign access   = mem_read_i | mem_write_i;
  assign illegal  = is_illegal(mem_read_i, mem_write_i, funct3_i);
  assign misalign = is_misaligned(funct3_i, addr_i[1:0]);
  assign busy     = (state_q == ST_BUSY);

  // Store steering is only needed in IDLE and load extraction only in BUSY,
  // so one aligner serves both by switching its size/offset source.
  assign al_funct3  = busy ? funct3_q : funct3_i;
  assign al_addr_lo = busy ? addr_q[1:0] : addr_i[1:0];

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_addr_lo),
    .store_data_i (store_data_i),
    .rdata_i      (dmem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    stall_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access) begin
          stall_o = 1'b1;
          if (illegal) begin
            fault_d     = FLT_ILLEGAL;
            load_data_d = '0;
            state_d     = ST_RESP;
          end else if (misalign) begin
            fault_d     = FLT_MISALIGN;
            load_data_d = '0;
            state_d     = ST_RESP;
          end else begin
            addr_d   = addr_i;
            funct3_d = funct3_i;
            we_d     = mem_write_i;
            be_d     = al_be;
            wdata_d  = al_wdata;
            fault_d  = FLT_NONE;
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Ready is checked first so a completion on the last allowed cycle wins.
        if (dmem_ready_i) begin
          load_data_d = we_q ? '0 : al_load;
          state_d     = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_d == TO_V)) begin
          fault_d     = FLT_TIMEOUT;
          load_data_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      fault_q     <= FLT_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  // Request fields are only presented while the access is outstanding.
  assign dmem_req_o   = busy;
  assign dmem_we_o    = busy & we_q;
  assign dmem_addr_o  = busy ? {addr_q[DATA_W-1:2], 2'b00} : '0;
  assign dmem_wdata_o = busy ? wdata_q : '0;
  assign dmem_be_o    = busy ? be_q : '0;

  assign load_data_o  = load_data_q;
  assign done_o       = (state_q == ST_RESP);
  assign fault_o      = (state_q == ST_RESP) && (fault_q != FLT_NONE);
  assign fault_code_o = (state_q == ST_RESP) ? fault_q : FLT_NONE;

endmodule
